// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display formatter.
// The FMT_LZB_EN build option (leading-zero blanking) is applied in alu_result_fmt.
package alu_disp_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_DOT   = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FMT
    } fmt_state_t;

    // Smallest n with 10^n > 2^w: decimal positions needed for a w-bit magnitude.
    function automatic int dec_digits_for(input int w);
        longint lim;
        longint p;
        int     n;
        lim = longint'(1) << w;
        p   = 1;
        n   = 0;
        while (p <= lim) begin
            p = p * 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_cell (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/alu_result_fmt.sv
// Binary ALU result to 7-segment digit codes via sequential double-dabble.
// Build option FMT_LZB_EN: leading-zero blanking with a floating minus sign.
module alu_result_fmt
    import alu_disp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_signed,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  out_valid
);

    localparam int BCD_W = 4 * (DIGITS - 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef FMT_LZB_EN
    localparam logic [DIGITS-1:0] RST_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};
`else
    localparam logic [DIGITS-1:0] RST_BLANK = '0;
`endif

    // The leftmost position is kept free for the sign.
    generate
        if (dec_digits_for(DATA_W) > DIGITS - 1) begin : g_bad_digits
            $error("alu_result_fmt: DIGITS too small for DATA_W");
        end
    endgenerate

    fmt_state_t               state_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [DATA_W-1:0]        mag_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     neg_q;
    logic [4*DIGITS-1:0]      digits_q;
    logic [DIGITS-1:0]        blank_q;
    logic                     out_valid_q;

    logic                     neg_d;
    logic [DATA_W-1:0]        mag_d;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+DATA_W-1:0]  shift_v;
    logic [4*DIGITS-1:0]      fmt_digits;
    logic [DIGITS-1:0]        fmt_blank;

    // DATA_W-bit negate of the most negative input leaves its unsigned magnitude.
    assign neg_d = in_signed & in_data[DATA_W-1];
    assign mag_d = neg_d ? (-in_data) : in_data;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS - 1; gi++) begin : g_add3
            bcd_add3_cell u_add3 (
                .nib_i (bcd_q[4*gi +: 4]),
                .nib_o (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign shift_v = {bcd_adj, mag_q} << 1;

`ifdef FMT_LZB_EN
    logic [4*DIGITS-1:0] bcd_ext;
    int                  msd;

    assign bcd_ext = {4'h0, bcd_q};

    always_comb begin
        fmt_digits = '0;
        fmt_blank  = '0;
        msd        = 0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (bcd_q[4*i +: 4] != 4'h0) begin
                msd = i;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= msd) begin
                fmt_digits[4*i +: 4] = bcd_ext[4*i +: 4];
            end else if (neg_q && (i == msd + 1)) begin
                fmt_digits[4*i +: 4] = DIG_MINUS;
            end else begin
                fmt_blank[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        fmt_digits = {(neg_q ? DIG_MINUS : 4'h0), bcd_q};
        fmt_blank  = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            digits_q    <= '0;
            blank_q     <= RST_BLANK;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q   <= neg_d;
                        mag_q   <= mag_d;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= shift_v[BCD_W+DATA_W-1:DATA_W];
                    mag_q <= shift_v[DATA_W-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= FMT;
                    end
                end
                FMT: begin
                    digits_q    <= fmt_digits;
                    blank_q     <= fmt_blank;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign digits     = digits_q;
    assign blank_mask = blank_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_result_fmt.sv
// Scoreboard bench for alu_result_fmt: directed vectors push expectations,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_alu_result_fmt;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_signed;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic        out_valid;

`ifdef FMT_LZB_EN
    localparam logic [3:0] RST_BLANK = 4'b1110;
`else
    localparam logic [3:0] RST_BLANK = 4'b0000;
`endif

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b;
        logic [7:0]  din;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] last_d = 16'h0;
    logic [3:0]  last_b = RST_BLANK;

    alu_result_fmt #(.DATA_W(8), .DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_signed  (in_signed),
        .digits     (digits),
        .blank_mask (blank_mask),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop on each pulse; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_d = 16'h0;
            last_b = RST_BLANK;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("digits_in%02h", e.din), 32'(digits), 32'(e.d));
                chk($sformatf("blank_in%02h", e.din), 32'(blank_mask), 32'(e.b));
                chk($sformatf("latency_in%02h", e.din), 32'(cyc - e.acc), 32'd9);
                $display("out in=%02h digits=%04h blank=%b", e.din, digits, blank_mask);
            end
            last_d = digits;
            last_b = blank_mask;
        end else begin
            chk("hold_digits", 32'(digits), 32'(last_d));
            chk("hold_blank", 32'(blank_mask), 32'(last_b));
        end
    end

    // dl/bl: expected with blanking enabled; dp: expected digits without it.
    task automatic send(input logic [7:0] d, input logic s, input logic [15:0] dl,
                        input logic [3:0] bl, input logic [15:0] dp, input bit hold,
                        output int acc);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        acc = cyc;
        if (ok) begin
            @(posedge clk);
            #1;
            acc   = cyc;
            e.din = d;
            e.acc = acc;
`ifdef FMT_LZB_EN
            e.d = dl;
            e.b = bl;
`else
            e.d = dp;
            e.b = 4'b0000;
`endif
            sb_q.push_back(e);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        int a1;
        int a2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_blank", 32'(blank_mask), 32'(RST_BLANK));
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //        data   sgn  lzb digits  lzb blank  plain digits
        send(8'h80, 1'b1, 16'hA128, 4'b0000, 16'hA128, 1'b0, a1);
        send(8'hFB, 1'b1, 16'h00A5, 4'b1100, 16'hA005, 1'b0, a1);
        send(8'hFF, 1'b0, 16'h0255, 4'b1000, 16'h0255, 1'b0, a1);
        send(8'h00, 1'b0, 16'h0000, 4'b1110, 16'h0000, 1'b0, a1);
        send(8'h00, 1'b1, 16'h0000, 4'b1110, 16'h0000, 1'b0, a1);
        send(8'h7F, 1'b1, 16'h0127, 4'b1000, 16'h0127, 1'b0, a1);
        send(8'h9C, 1'b1, 16'hA100, 4'b0000, 16'hA100, 1'b0, a1);
        send(8'hF6, 1'b1, 16'h0A10, 4'b1000, 16'hA010, 1'b0, a1);
        send(8'hFF, 1'b1, 16'h00A1, 4'b1100, 16'hA001, 1'b0, a1);

        // Back-to-back with in_valid held: second accept exactly 10 edges later.
        send(8'd42, 1'b0, 16'h0042, 4'b1100, 16'h0042, 1'b1, a1);
        send(8'd7,  1'b0, 16'h0007, 4'b1110, 16'h0007, 1'b0, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd10);
        repeat (12) @(posedge clk);
        #1;

        // Reset three cycles into a conversion: abort, no pulse afterwards.
        send(8'd99, 1'b0, 16'h0099, 4'b1100, 16'h0099, 1'b0, a1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_blank", 32'(blank_mask), 32'(RST_BLANK));
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        send(8'd99, 1'b0, 16'h0099, 4'b1100, 16'h0099, 1'b0, a1);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
